// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: ascending enable, descending disable, PG timeout fault.
// Optional PG-loss monitor in RST_HOLD/ON is enabled by defining PWR_SEQ_PG_MON_EN.
module pwr_seq_ctrl #(
  parameter int NUM_RAILS     = 4,
  parameter int PG_TIMEOUT_MS = 50,
  parameter int SETTLE_MS     = 10,
  parameter int RST_HOLD_MS   = 100,
  parameter int OFF_DLY_MS    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 int_1ms_en,
  input  logic                 pwr_on_req,
  input  logic                 pwr_off_req,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 sys_rst_n,
  output logic                 busy,
  output logic                 fault,
  output logic [2:0]           fault_rail,
  output logic [2:0]           seq_state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_UP_WAIT   = 3'd1,
    S_UP_SETTLE = 3'd2,
    S_RST_HOLD  = 3'd3,
    S_ON        = 3'd4,
    S_DOWN      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [2:0] LAST_IDX    = 3'(NUM_RAILS - 1);
  localparam logic [9:0] PG_LAST     = 10'(PG_TIMEOUT_MS - 1);
  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_MS - 1);
  localparam logic [9:0] HOLD_LAST   = 10'(RST_HOLD_MS - 1);
  localparam logic [9:0] OFF_LAST    = 10'(OFF_DLY_MS - 1);

  state_t                 state, state_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [2:0]             fault_rail_nxt, fault_idx;
  logic [9:0]             ms_cnt;
  logic [NUM_RAILS-1:0]   rail_en_nxt;
  logic                   rst_n_nxt;
  logic                   set_bit, clr_bit, fault_go;
  logic                   pg_sel;

  wire pg_expire     = int_1ms_en && (ms_cnt == PG_LAST);
  wire settle_expire = int_1ms_en && (ms_cnt == SETTLE_LAST);
  wire hold_expire   = int_1ms_en && (ms_cnt == HOLD_LAST);
  wire off_expire    = int_1ms_en && (ms_cnt == OFF_LAST);

  always_comb begin
    pg_sel = 1'b0;
    for (int i = 0; i < NUM_RAILS; i++)
      if (idx == 3'(i)) pg_sel = pg[i];
  end

`ifdef PWR_SEQ_PG_MON_EN
  logic       pg_bad;
  logic [2:0] pg_bad_idx;

  // Scan downward so the lowest failing enabled rail wins.
  always_comb begin
    pg_bad     = 1'b0;
    pg_bad_idx = 3'd0;
    for (int i = NUM_RAILS - 1; i >= 0; i--)
      if (rail_en[i] && !pg[i]) begin
        pg_bad     = 1'b1;
        pg_bad_idx = 3'(i);
      end
  end
`endif

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    rail_en_nxt    = rail_en;
    rst_n_nxt      = sys_rst_n;
    fault_rail_nxt = fault_rail;
    set_bit        = 1'b0;
    clr_bit        = 1'b0;
    fault_go       = 1'b0;
    fault_idx      = idx;

    case (state)
      S_OFF: begin
        if (pwr_on_req && !pwr_off_req) begin
          state_nxt = S_UP_WAIT;
          idx_nxt   = 3'd0;
          set_bit   = 1'b1;
        end
      end
      S_UP_WAIT: begin
        if (pwr_off_req) begin
          state_nxt = S_DOWN;
          clr_bit   = 1'b1;
        end else if (pg_sel) begin
          state_nxt = S_UP_SETTLE;
        end else if (pg_expire) begin
          fault_go = 1'b1;
        end
      end
      S_UP_SETTLE: begin
        if (pwr_off_req) begin
          state_nxt = S_DOWN;
          clr_bit   = 1'b1;
        end else if (settle_expire) begin
          if (idx < LAST_IDX) begin
            idx_nxt   = idx + 3'd1;
            set_bit   = 1'b1;
            state_nxt = S_UP_WAIT;
          end else begin
            state_nxt = S_RST_HOLD;
          end
        end
      end
      S_RST_HOLD: begin
        if (pwr_off_req) begin
          state_nxt = S_DOWN;
          clr_bit   = 1'b1;
        end
`ifdef PWR_SEQ_PG_MON_EN
        else if (pg_bad) begin
          fault_go  = 1'b1;
          fault_idx = pg_bad_idx;
        end
`endif
        else if (hold_expire) begin
          state_nxt = S_ON;
          rst_n_nxt = 1'b1;
        end
      end
      S_ON: begin
        if (pwr_off_req) begin
          state_nxt = S_DOWN;
          clr_bit   = 1'b1;
          rst_n_nxt = 1'b0;
        end
`ifdef PWR_SEQ_PG_MON_EN
        else if (pg_bad) begin
          fault_go  = 1'b1;
          fault_idx = pg_bad_idx;
        end
`endif
      end
      S_DOWN: begin
        if (off_expire) begin
          if (idx != 3'd0) begin
            idx_nxt = idx - 3'd1;
            clr_bit = 1'b1;
          end else begin
            state_nxt = S_OFF;
          end
        end
      end
      S_FAULT: begin
        if (pwr_off_req) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase

    if (fault_go) begin
      state_nxt      = S_FAULT;
      fault_rail_nxt = fault_idx;
      rail_en_nxt    = '0;
      rst_n_nxt      = 1'b0;
    end

    // Enables are set/cleared at the index the sequencer moves to on this edge.
    for (int i = 0; i < NUM_RAILS; i++)
      if (idx_nxt == 3'(i)) begin
        if (set_bit) rail_en_nxt[i] = 1'b1;
        if (clr_bit) rail_en_nxt[i] = 1'b0;
      end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_OFF;
      idx        <= 3'd0;
      ms_cnt     <= 10'd0;
      rail_en    <= '0;
      sys_rst_n  <= 1'b0;
      fault_rail <= 3'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rail_en    <= rail_en_nxt;
      sys_rst_n  <= rst_n_nxt;
      fault_rail <= fault_rail_nxt;
      if ((state_nxt != state) || (idx_nxt != idx))
        ms_cnt <= 10'd0;
      else if (int_1ms_en)
        ms_cnt <= ms_cnt + 10'd1;
    end
  end

  assign seq_state = state;
  assign fault     = (state == S_FAULT);
  assign busy      = (state != S_OFF) && (state != S_ON) && (state != S_FAULT);

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with default parameters; 1 ms tick every 4 clocks,
// power-good model follows each rail enable after 8 clocks.
module tb_pwr_seq_ctrl;
  localparam int NR = 4;
  localparam int B  = 2000;

  logic          clock = 1'b0, reset = 1'b1, int_1ms_en = 1'b0;
  logic          pwr_on_req = 1'b0, pwr_off_req = 1'b0;
  logic [NR-1:0] pg, rail_en;
  logic [NR-1:0] pg_base = '0, pg_kill = '0, pg_glitch = '0;
  logic          sys_rst_n, busy, fault;
  logic [2:0]    fault_rail, seq_state;

  int   vectors = 0, miscompares = 0;
  int   tick_total = 0, stamp = 0, prev = 0;
  logic track = 1'b0, hi_seen = 1'b0;

  assign pg = pg_base & ~pg_kill & ~pg_glitch;

  pwr_seq_ctrl dut (
    .clock(clock), .reset(reset), .int_1ms_en(int_1ms_en),
    .pwr_on_req(pwr_on_req), .pwr_off_req(pwr_off_req), .pg(pg),
    .rail_en(rail_en), .sys_rst_n(sys_rst_n), .busy(busy), .fault(fault),
    .fault_rail(fault_rail), .seq_state(seq_state)
  );

  always #20 clock = ~clock;

  always @(posedge clock) if (int_1ms_en) tick_total <= tick_total + 1;

  initial begin : tick_gen
    forever begin
      repeat (3) @(negedge clock);
      int_1ms_en = 1'b1;
      @(negedge clock);
      int_1ms_en = 1'b0;
    end
  end

  // Each rail reports good 8 clocks after its enable, drops as soon as it is disabled.
  initial begin : pg_model
    int cnt [NR];
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        if (!rail_en[i]) cnt[i] = 0;
        else if (cnt[i] < 8) cnt[i] = cnt[i] + 1;
        pg_base[i] = (cnt[i] >= 8);
      end
      if (track && (rail_en[3] || rail_en[2])) hi_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic on, input logic off);
    pwr_on_req  = on;
    pwr_off_req = off;
    @(negedge clock);
    pwr_on_req  = 1'b0;
    pwr_off_req = 1'b0;
  endtask

  task automatic waitState(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (seq_state !== st && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(seq_state), 32'(st));
    stamp = tick_total;
  endtask

  task automatic waitRail(input string tag, input logic [NR-1:0] val, input int budget);
    int n = 0;
    while (rail_en !== val && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(rail_en), 32'(val));
    stamp = tick_total;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("rst_rail_en", 32'(rail_en), 0);
    checkOutput("rst_sys_rst_n", 32'(sys_rst_n), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_fault_rail", 32'(fault_rail), 0);
    checkOutput("rst_state", 32'(seq_state), 0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(1'b1, 1'b1);
    @(negedge clock);
    checkOutput("both_state", 32'(seq_state), 0);
    checkOutput("both_rail_en", 32'(rail_en), 0);

    applyStimulus(1'b1, 1'b0);
    checkOutput("up_rail0", 32'(rail_en), 32'b0001);
    checkOutput("up_state", 32'(seq_state), 1);
    checkOutput("up_busy", 32'(busy), 1);
    waitState("settle0", 3'd2, B); prev = stamp;
    waitRail("rail_0011", 4'b0011, B);
    checkOutput("settle0_ms", stamp - prev, 10);
    waitState("settle1", 3'd2, B); prev = stamp;
    waitRail("rail_0111", 4'b0111, B);
    checkOutput("settle1_ms", stamp - prev, 10);
    waitState("settle2", 3'd2, B); prev = stamp;
    waitRail("rail_1111", 4'b1111, B);
    checkOutput("settle2_ms", stamp - prev, 10);
    waitState("settle3", 3'd2, B); prev = stamp;
    waitState("rst_hold", 3'd3, B);
    checkOutput("settle3_ms", stamp - prev, 10);
    checkOutput("hold_sys_rst_n", 32'(sys_rst_n), 0);
    prev = stamp;
    waitState("on", 3'd4, B);
    checkOutput("hold_ms", stamp - prev, 100);
    checkOutput("on_sys_rst_n", 32'(sys_rst_n), 1);
    checkOutput("on_busy", 32'(busy), 0);
    checkOutput("on_rail_en", 32'(rail_en), 32'b1111);

    pg_glitch = 4'b0010;
    @(negedge clock);
    pg_glitch = 4'b0000;
    @(negedge clock);
`ifdef PWR_SEQ_PG_MON_EN
    checkOutput("mon_state", 32'(seq_state), 6);
    checkOutput("mon_fault_rail", 32'(fault_rail), 1);
    checkOutput("mon_rail_en", 32'(rail_en), 0);
    checkOutput("mon_sys_rst_n", 32'(sys_rst_n), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mon_clear", 32'(seq_state), 0);
    applyStimulus(1'b1, 1'b0);
    waitState("repower", 3'd4, B);
`else
    checkOutput("glitch_state", 32'(seq_state), 4);
    checkOutput("glitch_rail_en", 32'(rail_en), 32'b1111);
    checkOutput("glitch_fault", 32'(fault), 0);
`endif

    applyStimulus(1'b0, 1'b1);
    checkOutput("dn_sys_rst_n", 32'(sys_rst_n), 0);
    checkOutput("dn_rail_en", 32'(rail_en), 32'b0111);
    checkOutput("dn_state", 32'(seq_state), 5);
    stamp = tick_total; prev = stamp;
    waitRail("dn_0011", 4'b0011, B);
    checkOutput("dn_0011_ms", stamp - prev, 5); prev = stamp;
    waitRail("dn_0001", 4'b0001, B);
    checkOutput("dn_0001_ms", stamp - prev, 5); prev = stamp;
    waitRail("dn_0000", 4'b0000, B);
    checkOutput("dn_0000_ms", stamp - prev, 5); prev = stamp;
    waitState("dn_off", 3'd0, B);
    checkOutput("dn_off_ms", stamp - prev, 5);

    track = 1'b1; hi_seen = 1'b0;
    applyStimulus(1'b1, 1'b0);
    waitRail("ab_0011", 4'b0011, B);
    waitState("ab_settle1", 3'd2, B);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ab_rail_en", 32'(rail_en), 32'b0001);
    checkOutput("ab_state", 32'(seq_state), 5);
    stamp = tick_total; prev = stamp;
    waitRail("ab_0000", 4'b0000, B);
    checkOutput("ab_0000_ms", stamp - prev, 5); prev = stamp;
    waitState("ab_off", 3'd0, B);
    checkOutput("ab_off_ms", stamp - prev, 5);
    track = 1'b0;
    checkOutput("ab_hi_rails", 32'(hi_seen), 0);

    pg_kill = 4'b0100;
    applyStimulus(1'b1, 1'b0);
    waitRail("to_0111", 4'b0111, B); prev = stamp;
    waitState("to_fault", 3'd6, B);
    checkOutput("to_ms", stamp - prev, 50);
    checkOutput("to_rail_en", 32'(rail_en), 0);
    checkOutput("to_fault", 32'(fault), 1);
    checkOutput("to_fault_rail", 32'(fault_rail), 2);
    checkOutput("to_sys_rst_n", 32'(sys_rst_n), 0);
    checkOutput("to_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("to_on_ignored", 32'(seq_state), 6);
    checkOutput("to_on_rail_en", 32'(rail_en), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to_clear_state", 32'(seq_state), 0);
    checkOutput("to_clear_fault", 32'(fault), 0);
    pg_kill = 4'b0000;

    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_up_wait", 32'(seq_state), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rail_en", 32'(rail_en), 0);
    checkOutput("mid_state", 32'(seq_state), 0);
    checkOutput("mid_sys_rst_n", 32'(sys_rst_n), 0);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_fault_rail", 32'(fault_rail), 0);
    reset = 1'b0;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #4000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
